// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking output under `BCD_LEADING_ZERO_BLANK_EN.
module bcd_seq_converter #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      in_bin,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow,
   output logic                  out_valid,
   input  logic                  out_ready
`ifdef BCD_LEADING_ZERO_BLANK_EN
   ,
   output logic [DIGITS-1:0]     blank_n
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [WIDTH-1:0]    bin_sr;
   logic [4*DIGITS-1:0] acc;
   logic [4*DIGITS-1:0] adj;
   logic [CW-1:0]       cnt;
   logic                ovf;
   logic                load;
   logic                shift_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      shift_en   = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load       = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt == CW'(1)) begin
               next_state = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Add-3 correction per digit; the 4-bit add keeps any carry inside its digit.
   always_comb begin
      adj = acc;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (acc[4*d +: 4] >= 4'd5) begin
            adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bin_sr <= '0;
         acc    <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else if (load) begin
         bin_sr <= in_bin;
         acc    <= '0;
         cnt    <= CW'(WIDTH);
         ovf    <= 1'b0;
      end else if (shift_en) begin
         bin_sr <= bin_sr << 1;
         acc    <= {adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
         cnt    <= cnt - CW'(1);
         if (adj[4*DIGITS-1]) begin
            ovf <= 1'b1;
         end
      end
   end

   assign bcd      = acc;
   assign overflow = ovf;

`ifdef BCD_LEADING_ZERO_BLANK_EN
   // Scan from the top digit down; a digit is shown once any digit at or above it is nonzero.
   logic seen_nz;
   always_comb begin
      blank_n = '0;
      seen_nz = 1'b0;
      for (int unsigned j = 0; j < DIGITS - 1; j++) begin
         seen_nz = seen_nz | (|acc[4*(DIGITS-1-j) +: 4]);
         blank_n[DIGITS-1-j] = seen_nz;
      end
      blank_n[0] = 1'b1;
   end
`endif

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: four instances (8x3, 8x2, 16x5, 1x1),
// random and directed stimulus checked against an arithmetic decimal model.
module tb_bcd_seq_converter;

   typedef struct {
      longint v;
      longint acc_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic rst_cd;
   longint cyc = 0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // A (8x3) and B (8x2) share stimulus; C (16x5) and D (1x1) run independently.
   logic [7:0]  ab_in_bin;
   logic        ab_in_valid, ab_out_ready;
   logic        a_in_ready, a_ovf, a_valid, b_in_ready, b_ovf, b_valid;
   logic [11:0] a_bcd;
   logic [7:0]  b_bcd;
   logic [15:0] c_in_bin;
   logic        c_in_valid, c_in_ready, c_ovf, c_valid;
   logic [19:0] c_bcd;
   logic [0:0]  d_in_bin;
   logic        d_in_valid, d_in_ready, d_ovf, d_valid;
   logic [3:0]  d_bcd;
   logic        cd_out_ready;
`ifdef BCD_LEADING_ZERO_BLANK_EN
   logic [2:0]  a_blank;
   logic [1:0]  b_blank;
   logic [4:0]  c_blank;
   logic [0:0]  d_blank;
`endif

   bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) u_a (
      .clk(clk), .reset(rst), .in_bin(ab_in_bin), .in_valid(ab_in_valid),
      .in_ready(a_in_ready), .bcd(a_bcd), .overflow(a_ovf), .out_valid(a_valid),
      .out_ready(ab_out_ready)
`ifdef BCD_LEADING_ZERO_BLANK_EN
      , .blank_n(a_blank)
`endif
   );

   bcd_seq_converter #(.WIDTH(8), .DIGITS(2)) u_b (
      .clk(clk), .reset(rst), .in_bin(ab_in_bin), .in_valid(ab_in_valid),
      .in_ready(b_in_ready), .bcd(b_bcd), .overflow(b_ovf), .out_valid(b_valid),
      .out_ready(ab_out_ready)
`ifdef BCD_LEADING_ZERO_BLANK_EN
      , .blank_n(b_blank)
`endif
   );

   bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) u_c (
      .clk(clk), .reset(rst_cd), .in_bin(c_in_bin), .in_valid(c_in_valid),
      .in_ready(c_in_ready), .bcd(c_bcd), .overflow(c_ovf), .out_valid(c_valid),
      .out_ready(cd_out_ready)
`ifdef BCD_LEADING_ZERO_BLANK_EN
      , .blank_n(c_blank)
`endif
   );

   bcd_seq_converter #(.WIDTH(1), .DIGITS(1)) u_d (
      .clk(clk), .reset(rst_cd), .in_bin(d_in_bin), .in_valid(d_in_valid),
      .in_ready(d_in_ready), .bcd(d_bcd), .overflow(d_ovf), .out_valid(d_valid),
      .out_ready(cd_out_ready)
`ifdef BCD_LEADING_ZERO_BLANK_EN
      , .blank_n(d_blank)
`endif
   );

   exp_t qa[$], qb[$], qc[$], qd[$];
   exp_t ea, eb, ec, ed;
   logic a_prev = 1'b0, b_prev = 1'b0, c_prev = 1'b0, d_prev = 1'b0;
   longint a_last_acc;

   // ---------------- reference model ----------------
   function automatic longint pow10(input int d);
      longint p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [63:0] to_bcd(input longint v, input int d);
      logic [63:0] r = '0;
      longint x = v;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [63:0] blank_exp(input longint v, input int d);
      logic [63:0] r = '0;
      longint shown = v % pow10(d);
      for (int i = 0; i < d; i++) r[i] = (i == 0) || (shown >= pow10(i));
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (a_valid && !a_prev) begin
         if (qa.size() == 0) check("a_spurious_valid", 1, 0);
         else begin
            ea = qa.pop_front();
            check("a_bcd", a_bcd, to_bcd(ea.v, 3));
            check("a_ovf", a_ovf, ea.v >= pow10(3));
            check("a_latency", cyc - ea.acc_cyc, 8);
`ifdef BCD_LEADING_ZERO_BLANK_EN
            check("a_blank_n", a_blank, blank_exp(ea.v, 3));
`endif
         end
      end else if (a_valid) begin
         check("a_bcd_held", a_bcd, to_bcd(ea.v, 3));
      end
      if (b_valid && !b_prev) begin
         if (qb.size() == 0) check("b_spurious_valid", 1, 0);
         else begin
            eb = qb.pop_front();
            check("b_bcd", b_bcd, to_bcd(eb.v, 2));
            check("b_ovf", b_ovf, eb.v >= pow10(2));
            check("b_latency", cyc - eb.acc_cyc, 8);
         end
      end
      a_prev = a_valid;
      b_prev = b_valid;
   end

   always @(negedge clk) begin
      if (c_valid && !c_prev) begin
         if (qc.size() == 0) check("c_spurious_valid", 1, 0);
         else begin
            ec = qc.pop_front();
            check("c_bcd", c_bcd, to_bcd(ec.v, 5));
            check("c_ovf", c_ovf, ec.v >= pow10(5));
            check("c_latency", cyc - ec.acc_cyc, 16);
         end
      end
      if (d_valid && !d_prev) begin
         if (qd.size() == 0) check("d_spurious_valid", 1, 0);
         else begin
            ed = qd.pop_front();
            check("d_bcd", d_bcd, to_bcd(ed.v, 1));
            check("d_ovf", d_ovf, ed.v >= pow10(1));
            check("d_latency", cyc - ed.acc_cyc, 1);
         end
      end
      c_prev = c_valid;
      d_prev = d_valid;
   end

   // ---------------- drivers (called at a negedge, return at a negedge) ----------------
   task automatic issue_ab(input logic [7:0] v);
      exp_t e;
      check("a_in_ready_idle", a_in_ready, 1);
      check("b_in_ready_idle", b_in_ready, 1);
      ab_in_bin   = v;
      ab_in_valid = 1'b1;
      e.v = longint'(v);
      e.acc_cyc = cyc + 1;
      a_last_acc = e.acc_cyc;
      qa.push_back(e);
      qb.push_back(e);
      @(negedge clk);
      ab_in_valid = 1'b0;
   endtask

   task automatic convert_ab(input logic [7:0] v, input int hold);
      int n = 0;
      issue_ab(v);
      // in_bin/in_valid/out_ready are randomised while shifting; all must be ignored
      while (!a_valid && n < 40) begin
         check("a_in_ready_busy", a_in_ready, 0);
         ab_in_valid  = 1'($urandom_range(0, 1));
         ab_in_bin    = 8'($urandom);
         ab_out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      if (!a_valid) check("a_timeout", 0, 1);
      ab_in_valid  = 1'b0;
      ab_out_ready = (hold == 0);
      for (int i = 0; i < hold; i++) begin
         check("a_in_ready_done", a_in_ready, 0);
         ab_in_valid = 1'b1;
         ab_in_bin   = 8'($urandom);
         @(negedge clk);
         ab_in_valid = 1'b0;
         check("a_valid_held", a_valid, 1);
      end
      ab_out_ready = 1'b1;
      @(negedge clk);
      check("a_valid_drop", a_valid, 0);
   endtask

   task automatic drive_ab();
      longint t0;
      convert_ab(8'd255, 0);
      convert_ab(8'd0, 0);
      t0 = a_last_acc;
      convert_ab(8'd9, 0);
      check("a_accept_interval", (a_last_acc - t0) >= 10, 1);
      convert_ab(8'd128, 20);
      convert_ab(8'd42, 0);
      // abort a conversion of 200 three cycles in
      issue_ab(8'd200);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_in_ready", a_in_ready, 1);
      check("abort_out_valid", a_valid, 0);
      check("abort_bcd", a_bcd, 0);
      check("abort_ovf", a_ovf, 0);
      check("abort_b_bcd", b_bcd, 0);
`ifdef BCD_LEADING_ZERO_BLANK_EN
      check("abort_blank_n", a_blank, 3'b001);
`endif
      void'(qa.pop_back());
      void'(qb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("abort_no_valid", a_valid | b_valid, 0);
      end
      convert_ab(8'd37, 0);
      for (int i = 0; i < 30; i++) convert_ab(8'($urandom), int'($urandom_range(0, 3)));
   endtask

   task automatic convert_c(input logic [15:0] v);
      exp_t e;
      int n = 0;
      check("c_in_ready_idle", c_in_ready, 1);
      c_in_bin = v;
      c_in_valid = 1'b1;
      e.v = longint'(v);
      e.acc_cyc = cyc + 1;
      qc.push_back(e);
      @(negedge clk);
      c_in_valid = 1'b0;
      while (!c_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!c_valid) check("c_timeout", 0, 1);
      @(negedge clk);
   endtask

   task automatic drive_c();
      convert_c(16'd65535);
      convert_c(16'd0);
      convert_c(16'd10000);
      convert_c(16'd9999);
      for (int i = 0; i < 20; i++) convert_c(16'($urandom));
   endtask

   task automatic convert_d(input logic [0:0] v);
      exp_t e;
      int n = 0;
      check("d_in_ready_idle", d_in_ready, 1);
      d_in_bin = v;
      d_in_valid = 1'b1;
      e.v = longint'(v);
      e.acc_cyc = cyc + 1;
      qd.push_back(e);
      @(negedge clk);
      d_in_valid = 1'b0;
      while (!d_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!d_valid) check("d_timeout", 0, 1);
      @(negedge clk);
   endtask

   task automatic drive_d();
      convert_d(1'b0);
      convert_d(1'b1);
      for (int i = 0; i < 12; i++) convert_d(1'($urandom));
   endtask

   // ---------------- main ----------------
   initial begin
      rst = 1'b1;
      rst_cd = 1'b1;
      ab_in_bin = '0;
      ab_in_valid = 1'b0;
      ab_out_ready = 1'b1;
      c_in_bin = '0;
      c_in_valid = 1'b0;
      d_in_bin = '0;
      d_in_valid = 1'b0;
      cd_out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_in_ready", a_in_ready, 1);
      check("reset_out_valid", a_valid, 0);
      check("reset_bcd", a_bcd, 0);
      check("reset_ovf", a_ovf, 0);
      check("reset_c_bcd", c_bcd, 0);
`ifdef BCD_LEADING_ZERO_BLANK_EN
      check("reset_blank_n", a_blank, 3'b001);
`endif
      rst = 1'b0;
      rst_cd = 1'b0;
      @(negedge clk);
      fork
         drive_ab();
         drive_c();
         drive_d();
      join
      repeat (5) @(negedge clk);
      check("a_queue_drained", qa.size(), 0);
      check("b_queue_drained", qb.size(), 0);
      check("c_queue_drained", qc.size(), 0);
      check("d_queue_drained", qd.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog simulation did not complete (t=%0t)", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
